// File: rtl/osd_pkg.sv
// ---------------------------------------------------------------------------
// osd_pkg
// Shared definitions for the OSD text path (text buffer geometry, the
// character-write state encoding and the nibble-to-ASCII helper). Used by
// the hex value scheduler and its sibling text writers.
// ---------------------------------------------------------------------------
package osd_pkg;

    localparam int OSD_COLS   = 16;
    localparam int OSD_ROWS   = 8;
    localparam int OSD_ADDR_W = 7;

    localparam logic [1:0] OSD_ST_IDLE = 2'd0;
    localparam logic [1:0] OSD_ST_HI   = 2'd1;
    localparam logic [1:0] OSD_ST_LO   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = OSD_ST_IDLE,
        ST_HI   = OSD_ST_HI,
        ST_LO   = OSD_ST_LO
    } osd_state_e;

    // Uppercase hex digit: 0-9 map to '0'-'9', 10-15 map to 'A'-'F'.
    function automatic logic [7:0] hex_to_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h37 + {4'h0, nib};
    endfunction

endpackage

// File: rtl/osd_hex_value_scheduler_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick: returns the first asserted request
// at or after ptr, searching cyclically.
//   req         in   N      request vector
//   ptr         in   PTR_W  index where the search starts (must be < N)
//   grant_valid out  1      at least one request is asserted
//   grant_idx   out  PTR_W  index of the granted request
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic             grant_valid,
    output logic [PTR_W-1:0] grant_idx
);

    // Walk the offsets from ptr outward; the first hit wins. The inner loop
    // only indexes req with constant loop variables, which keeps the search
    // a flat mux tree after unrolling.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int off = 0; off < N; off++) begin
            for (int i = 0; i < N; i++) begin
                if (!grant_valid && req[i] &&
                    ((32'(ptr) + 32'(off)) % 32'(N) == 32'(i))) begin
                    grant_valid = 1'b1;
                    grant_idx   = PTR_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/osd_hex_value_scheduler.sv
// ---------------------------------------------------------------------------
// osd_hex_value_scheduler
// Feeds the single write port of the OSD text buffer. Watches NUM_VALUES
// 8-bit debug values, each with its own screen position, and whenever a
// value differs from what was last drawn (or a refresh is forced) writes it
// as two uppercase hex characters. Slots are served round-robin, one value
// per three cycles (IDLE grant, HI digit, LO digit).
//   clk           in   1              system clock
//   reset         in   1              asynchronous, active-high
//   vblank        in   1              vertical blank, gates new grants if BLANK_ONLY
//   force_refresh in   1              one-cycle pulse, marks every slot pending
//   values_in     in   NUM_VALUES*8   slot i value at [i*8 +: 8]
//   pos_line      in   NUM_VALUES*3   slot i text line
//   pos_col       in   NUM_VALUES*4   slot i column of the high digit
//   wr_addr       out  7              text buffer write address (line*COLS+col)
//   wr_data       out  8              ASCII character
//   wr_en         out  1              text buffer write strobe
//   busy          out  1              high while a HI/LO pair is being written
// ---------------------------------------------------------------------------
module osd_hex_value_scheduler
    import osd_pkg::*;
#(
    parameter int NUM_VALUES = 4,
    parameter int COLS       = OSD_COLS,
    parameter int ROWS       = OSD_ROWS,
    parameter int BLANK_ONLY = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    vblank,
    input  logic                    force_refresh,
    input  logic [NUM_VALUES*8-1:0] values_in,
    input  logic [NUM_VALUES*3-1:0] pos_line,
    input  logic [NUM_VALUES*4-1:0] pos_col,
    output logic [OSD_ADDR_W-1:0]   wr_addr,
    output logic [7:0]              wr_data,
    output logic                    wr_en,
    output logic                    busy
);

    localparam int PTR_W = (NUM_VALUES > 1) ? $clog2(NUM_VALUES) : 1;

    // Elaboration-time sanity on the geometry; a bad build stops here rather
    // than producing silently aliased addresses.
    if (NUM_VALUES < 1 || NUM_VALUES > 8) begin : g_bad_num_values
        $error("NUM_VALUES must be in 1..8");
    end
    if (COLS * ROWS > (1 << OSD_ADDR_W) || COLS > 16) begin : g_bad_geometry
        $error("COLS*ROWS must fit the 7-bit text buffer address and COLS <= 16");
    end

    // Registered state
    osd_state_e              state_q, state_d;
    logic [7:0]              val_q, val_d;
    logic [2:0]              line_q, line_d;
    logic [3:0]              col_q, col_d;
    logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [7:0]              shadow_q [NUM_VALUES];
    logic [7:0]              shadow_d [NUM_VALUES];
    logic [NUM_VALUES-1:0]   force_q, force_d;
    logic                    wr_en_q, wr_en_d;
    logic [OSD_ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [7:0]              wr_data_q, wr_data_d;

    // Per-slot views of the packed input buses
    logic [7:0]              slot_val  [NUM_VALUES];
    logic [2:0]              slot_line [NUM_VALUES];
    logic [3:0]              slot_col  [NUM_VALUES];
    logic [NUM_VALUES-1:0]   pending;

    // Arbiter result and the granted slot's inputs
    logic                    grant_valid;
    logic [PTR_W-1:0]        grant_idx;
    logic [7:0]              sel_val;
    logic [2:0]              sel_line;
    logic [3:0]              sel_col;
    logic                    grant_ok;

    // Linear text-buffer address. Out-of-range lines simply truncate to the
    // address width; the text buffer is the authority on what is visible.
    function automatic logic [OSD_ADDR_W-1:0] cell_addr(input logic [2:0] line,
                                                        input logic [3:0] col);
        logic [31:0] full;
        full = 32'(line) * 32'(COLS) + 32'(col);
        return full[OSD_ADDR_W-1:0];
    endfunction

    // The low digit sits one column right of the high digit and wraps to
    // column 0 of the same line rather than spilling onto the next line.
    function automatic logic [3:0] next_col(input logic [3:0] col);
        if (32'(col) == 32'(COLS - 1)) begin
            return 4'd0;
        end
        return col + 4'd1;
    endfunction

    // A slot needs service when its live value differs from what was last
    // drawn, or when a refresh has been requested for it.
    always_comb begin
        for (int i = 0; i < NUM_VALUES; i++) begin
            slot_val[i]  = values_in[i*8 +: 8];
            slot_line[i] = pos_line[i*3 +: 3];
            slot_col[i]  = pos_col[i*4 +: 4];
            pending[i]   = (slot_val[i] != shadow_q[i]) | force_q[i];
        end
    end

    rr_arbiter #(
        .N     (NUM_VALUES),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .req         (pending),
        .ptr         (rr_ptr_q),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // Mux out the granted slot's value and position.
    always_comb begin
        sel_val  = '0;
        sel_line = '0;
        sel_col  = '0;
        for (int i = 0; i < NUM_VALUES; i++) begin
            if (32'(grant_idx) == 32'(i)) begin
                sel_val  = slot_val[i];
                sel_line = slot_line[i];
                sel_col  = slot_col[i];
            end
        end
    end

    // New services only start during blank when BLANK_ONLY is set; a pair
    // that has already started always runs to completion.
    assign grant_ok = grant_valid && ((BLANK_ONLY == 0) || vblank);

    // Next-state logic. The write strobe, address and data are computed one
    // cycle ahead so they come straight from flops: the HI character is
    // presented in the cycle after the grant, the LO character the cycle after.
    always_comb begin
        state_d   = state_q;
        val_d     = val_q;
        line_d    = line_q;
        col_d     = col_q;
        rr_ptr_d  = rr_ptr_q;
        shadow_d  = shadow_q;
        force_d   = force_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_ok) begin
                    state_d   = ST_HI;
                    val_d     = sel_val;
                    line_d    = sel_line;
                    col_d     = sel_col;
                    if (32'(grant_idx) == 32'(NUM_VALUES - 1)) begin
                        rr_ptr_d = '0;
                    end else begin
                        rr_ptr_d = grant_idx + PTR_W'(1);
                    end
                    for (int i = 0; i < NUM_VALUES; i++) begin
                        if (32'(grant_idx) == 32'(i)) begin
                            shadow_d[i] = sel_val;
                            force_d[i]  = 1'b0;
                        end
                    end
                    wr_en_d   = 1'b1;
                    wr_addr_d = cell_addr(sel_line, sel_col);
                    wr_data_d = hex_to_ascii(sel_val[7:4]);
                end
            end
            ST_HI: begin
                state_d   = ST_LO;
                wr_en_d   = 1'b1;
                wr_addr_d = cell_addr(line_q, next_col(col_q));
                wr_data_d = hex_to_ascii(val_q[3:0]);
            end
            ST_LO: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A refresh request overrides the grant's clear, so a refresh that
        // lands in the grant cycle still redraws the slot later.
        if (force_refresh) begin
            force_d = '1;
        end
    end

    // State and output registers. Reset marks every slot forced so the
    // first frame after reset (or a reset that cut a pair in half) redraws
    // everything.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            val_q     <= '0;
            line_q    <= '0;
            col_q     <= '0;
            rr_ptr_q  <= '0;
            for (int i = 0; i < NUM_VALUES; i++) begin
                shadow_q[i] <= '0;
            end
            force_q   <= '1;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            val_q     <= val_d;
            line_q    <= line_d;
            col_q     <= col_d;
            rr_ptr_q  <= rr_ptr_d;
            shadow_q  <= shadow_d;
            force_q   <= force_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = (state_q != ST_IDLE);

endmodule
